ho_bs_controller: RTL and testbench

- Parametrised successor to the fixed three-station base-station FSM in the handover system. One instance per base station, for NUM_BS stations.
- Accepts nominations from peer stations and serves the mobile device.
- Starts a handover only after signal quality stays low for a hysteresis window. Queries the device manager (DM) with timeout and retry, then nominates the chosen peer and reports the new target to the server (SV).

---
 rtl/ho_pkg.sv | 31 +++
 rtl/ho_sq_monitor.sv | 36 +++
 rtl/ho_bs_controller.sv | 132 +++++++++++++
 tb/tb_ho_bs_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ho_pkg.sv
// rtl/ho_pkg.sv - shared state encoding, defaults and helpers for base-station controllers
package ho_pkg;

    typedef enum logic [2:0] {
        HO_IDLE    = 3'd0,
        HO_ADMIT   = 3'd1,
        HO_SERVE   = 3'd2,
        HO_QUERY   = 3'd3,
        HO_HANDOFF = 3'd4,
        HO_REPORT  = 3'd5
    } ho_state_t;

    localparam int DEF_SQ_THRESH   = 50;
    localparam int DEF_HYST_CYCLES = 4;
    localparam int DEF_TIMEOUT     = 16;
    localparam int DEF_MAX_RETRY   = 2;

    // Callers size-cast the result down to their station count.
    function automatic logic [31:0] onehot(input int idx, input int n);
        logic [31:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < 32)
            v = 32'd1 << idx;
        return v;
    endfunction

    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ho_sq_monitor.sv
// rtl/ho_sq_monitor.sv - counts consecutive low-quality samples and flags the hysteresis hit
module ho_sq_monitor
    import ho_pkg::*;
#(
    parameter int SQ_W        = 8,
    parameter int SQ_THRESH   = DEF_SQ_THRESH,
    parameter int HYST_CYCLES = DEF_HYST_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [SQ_W-1:0] sq,
    output logic            low_done
);

    localparam int CNT_W = cnt_w(HYST_CYCLES);

    logic [CNT_W-1:0] low_cnt;
    logic             is_low;

    assign is_low   = 32'(sq) < 32'(SQ_THRESH);
    // Asserted on the sample that would complete the run, so the FSM leaves on that same edge.
    assign low_done = enable && is_low && (32'(low_cnt) + 32'd1 >= 32'(HYST_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            low_cnt <= '0;
        end else if (is_low) begin
            if (32'(low_cnt) < 32'(HYST_CYCLES))
                low_cnt <= low_cnt + 1'b1;
        end else begin
            low_cnt <= '0;
        end
    end

endmodule

// File: rtl/ho_bs_controller.sv
// rtl/ho_bs_controller.sv - per-station handover FSM: admit, serve, query DM, nominate peer, report
module ho_bs_controller
    import ho_pkg::*;
#(
    parameter int NUM_BS      = 3,
    parameter int BS_ID       = 2,
    parameter int SQ_W        = 8,
    parameter int SQ_THRESH   = DEF_SQ_THRESH,
    parameter int HYST_CYCLES = DEF_HYST_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int DATA_W      = 8,
    localparam int ID_W       = (NUM_BS > 2) ? $clog2(NUM_BS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_BS-1:0] peer_target_i,
    input  logic [SQ_W-1:0]   dm_sq_i,
    input  logic              dm_target_valid_i,
    input  logic [ID_W-1:0]   dm_target_i,
    input  logic [DATA_W-1:0] sv_data_i,
    output logic              dm_respond_o,
    output logic              dm_request_o,
    output logic [DATA_W-1:0] dm_data_o,
    output logic [NUM_BS-1:0] peer_target_o,
    output logic              sv_target_valid_o,
    output logic [ID_W-1:0]   sv_target_o,
    output logic              ho_fail_o
);

    localparam logic [2:0] S_IDLE    = HO_IDLE;
    localparam logic [2:0] S_ADMIT   = HO_ADMIT;
    localparam logic [2:0] S_SERVE   = HO_SERVE;
    localparam logic [2:0] S_QUERY   = HO_QUERY;
    localparam logic [2:0] S_HANDOFF = HO_HANDOFF;
    localparam logic [2:0] S_REPORT  = HO_REPORT;

    localparam int TMR_W = cnt_w(TIMEOUT);
    localparam int RTY_W = cnt_w(MAX_RETRY);
    localparam logic [NUM_BS-1:0] SELF_MASK = NUM_BS'(onehot(BS_ID, NUM_BS));

    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [RTY_W-1:0]  retry_q;
    logic [ID_W-1:0]   tgt_q;
    logic [NUM_BS-1:0] tgt_onehot;
    logic              low_done, nominated, tgt_ok, stay, timeout, give_up;

    ho_sq_monitor #(
        .SQ_W        (SQ_W),
        .SQ_THRESH   (SQ_THRESH),
        .HYST_CYCLES (HYST_CYCLES)
    ) u_sq_monitor (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q == S_SERVE),
        .sq       (dm_sq_i),
        .low_done (low_done)
    );

    assign nominated  = |(peer_target_i & ~SELF_MASK);
    assign tgt_ok     = dm_target_valid_i && (32'(dm_target_i) < 32'(NUM_BS))
                        && (32'(dm_target_i) != 32'(BS_ID));
    assign stay       = dm_target_valid_i && !tgt_ok;
    assign timeout    = 32'(timer_q) + 32'd1 >= 32'(TIMEOUT);
    assign give_up    = timeout && (32'(retry_q) + 32'd1 >= 32'(MAX_RETRY));
    assign tgt_onehot = NUM_BS'(onehot(int'(dm_target_i), NUM_BS));

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = nominated ? S_ADMIT : S_IDLE;
            S_ADMIT:   state_d = S_SERVE;
            S_SERVE:   state_d = low_done ? S_QUERY : S_SERVE;
            S_QUERY: begin
                // A DM answer takes priority over a coincident timeout.
                if (tgt_ok)
                    state_d = S_HANDOFF;
                else if (stay || give_up)
                    state_d = S_SERVE;
                else
                    state_d = S_QUERY;
            end
            S_HANDOFF: state_d = S_REPORT;
            S_REPORT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the cycle the FSM occupies it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            timer_q           <= '0;
            retry_q           <= '0;
            tgt_q             <= '0;
            dm_respond_o      <= 1'b0;
            dm_request_o      <= 1'b0;
            dm_data_o         <= '0;
            peer_target_o     <= '0;
            sv_target_valid_o <= 1'b0;
            sv_target_o       <= '0;
            ho_fail_o         <= 1'b0;
        end else begin
            state_q           <= state_d;
            dm_respond_o      <= (state_d == S_ADMIT) || (state_d == S_SERVE) || (state_d == S_QUERY);
            dm_request_o      <= (state_d == S_QUERY);
            dm_data_o         <= ((state_d == S_SERVE) || (state_d == S_QUERY)) ? sv_data_i : '0;
            peer_target_o     <= (state_d == S_HANDOFF) ? tgt_onehot : '0;
            sv_target_valid_o <= (state_d == S_REPORT);
            sv_target_o       <= (state_d == S_REPORT) ? tgt_q : '0;
            ho_fail_o         <= (state_q == S_QUERY) && !dm_target_valid_i && give_up;

            if (state_q == S_QUERY && tgt_ok)
                tgt_q <= dm_target_i;

            if (state_q == S_QUERY && state_d == S_QUERY) begin
                if (timeout) begin
                    timer_q <= '0;
                    if (32'(retry_q) < 32'(MAX_RETRY))
                        retry_q <= retry_q + 1'b1;
                end else if (32'(timer_q) < 32'(TIMEOUT)) begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                timer_q <= '0;
                retry_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ho_bs_controller.sv
// tb/tb_ho_bs_controller.sv - scoreboard bench for the base-station handover controller
module tb_ho_bs_controller;

    localparam int NUM_BS = 3;
    localparam int ID_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_BS-1:0] peer_target_i;
    logic [7:0]        dm_sq_i;
    logic              dm_target_valid_i;
    logic [ID_W-1:0]   dm_target_i;
    logic [7:0]        sv_data_i;
    logic              dm_respond_o, dm_request_o;
    logic [7:0]        dm_data_o;
    logic [NUM_BS-1:0] peer_target_o;
    logic              sv_target_valid_o;
    logic [ID_W-1:0]   sv_target_o;
    logic              ho_fail_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    localparam int EV_PEER = 1;
    localparam int EV_SV   = 2;
    localparam int EV_FAIL = 3;

    ev_t exp_q[$];

    ho_bs_controller #(
        .NUM_BS(NUM_BS), .BS_ID(2), .SQ_W(8), .SQ_THRESH(50), .HYST_CYCLES(4),
        .TIMEOUT(16), .MAX_RETRY(2), .DATA_W(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .peer_target_i     (peer_target_i),
        .dm_sq_i           (dm_sq_i),
        .dm_target_valid_i (dm_target_valid_i),
        .dm_target_i       (dm_target_i),
        .sv_data_i         (sv_data_i),
        .dm_respond_o      (dm_respond_o),
        .dm_request_o      (dm_request_o),
        .dm_data_o         (dm_data_o),
        .peer_target_o     (peer_target_o),
        .sv_target_valid_o (sv_target_valid_o),
        .sv_target_o       (sv_target_o),
        .ho_fail_o         (ho_fail_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual kind=%0d val=%0h required none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event actual kind=%0d val=%0h required kind=%0d val=%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (peer_target_o != '0) observe(EV_PEER, int'(peer_target_o));
            if (sv_target_valid_o)   observe(EV_SV, int'(sv_target_o));
            if (ho_fail_o)           observe(EV_FAIL, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_respond"}, dm_respond_o, 0);
        chk({name, "_request"}, dm_request_o, 0);
        chk({name, "_data"}, dm_data_o, 0);
        chk({name, "_peer"}, peer_target_o, 0);
        chk({name, "_svv"}, sv_target_valid_o, 0);
        chk({name, "_fail"}, ho_fail_o, 0);
    endtask

    task automatic admit(input logic [NUM_BS-1:0] nom);
        peer_target_i = nom;
        tick();
        peer_target_i = '0;
        tick();
    endtask

    // Drives n low samples; request must stay low until the last one.
    task automatic lows_to_query(input string name, input int n);
        for (int i = 1; i <= n; i++) begin
            dm_sq_i = 8'd10;
            tick();
            chk($sformatf("%s_req%0d", name, i), dm_request_o, (i == n) ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        logic [7:0] sq_seq [7];
        sq_seq = '{8'd40, 8'd40, 8'd60, 8'd40, 8'd40, 8'd40, 8'd40};

        reset = 1'b1; peer_target_i = '0; dm_sq_i = 8'd100;
        dm_target_valid_i = 1'b0; dm_target_i = '0; sv_data_i = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        chk("reset_sv_target", sv_target_o, 0);
        reset = 1'b0;

        peer_target_i = 3'b100;
        tick();
        chk("self_nom_ignored", dm_respond_o, 0);

        peer_target_i = 3'b001; sv_data_i = 8'hA5;
        tick();
        peer_target_i = '0;
        chk("admit_respond", dm_respond_o, 1);
        chk("admit_data", dm_data_o, 0);
        tick();
        chk("serve_respond", dm_respond_o, 1);
        chk("serve_data", dm_data_o, 8'hA5);

        for (int i = 0; i < 7; i++) begin
            dm_sq_i = sq_seq[i];
            tick();
            chk($sformatf("hyst_req%0d", i), dm_request_o, (i == 6) ? 1 : 0);
        end
        dm_sq_i = 8'd100;
        sv_data_i = 8'h3C;
        tick();
        chk("query_data", dm_data_o, 8'h3C);
        chk("query_respond", dm_respond_o, 1);

        dm_target_valid_i = 1'b1; dm_target_i = 2'd1;
        expect_ev(EV_PEER, 3'b010);
        expect_ev(EV_SV, 1);
        tick();
        dm_target_valid_i = 1'b0;
        chk("handoff_respond", dm_respond_o, 0);
        chk("handoff_request", dm_request_o, 0);
        chk("handoff_data", dm_data_o, 0);
        tick();
        chk("report_peer_cleared", peer_target_o, 0);
        tick();
        chk_all_zero("idle_after_report");

        admit(3'b010);
        lows_to_query("stay_a", 4);
        dm_target_valid_i = 1'b1; dm_target_i = 2'd2;
        tick();
        dm_target_valid_i = 1'b0;
        chk("stay_own_respond", dm_respond_o, 1);
        chk("stay_own_request", dm_request_o, 0);
        lows_to_query("cleared_cnt", 4);
        dm_target_valid_i = 1'b1; dm_target_i = 2'd3;
        tick();
        dm_target_valid_i = 1'b0;
        chk("stay_range_respond", dm_respond_o, 1);
        chk("stay_range_request", dm_request_o, 0);

        lows_to_query("to_timeout", 4);
        dm_sq_i = 8'd100;
        expect_ev(EV_FAIL, 0);
        n = 0;
        @(negedge clk);
        while (dm_request_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_query_cycles", n, 32);
        chk("fail_pulse", ho_fail_o, 1);
        chk("fail_back_to_serve", dm_respond_o, 1);
        @(negedge clk);
        chk("fail_one_cycle", ho_fail_o, 0);

        #1;
        lows_to_query("tie", 4);
        repeat (31) tick();
        dm_target_valid_i = 1'b1; dm_target_i = 2'd0;
        expect_ev(EV_PEER, 3'b001);
        expect_ev(EV_SV, 0);
        tick();
        dm_target_valid_i = 1'b0;
        chk("tie_valid_wins_respond", dm_respond_o, 0);
        chk("tie_valid_wins_fail", ho_fail_o, 0);
        repeat (2) tick();

        admit(3'b011);
        lows_to_query("rst", 4);
        reset = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        reset = 1'b0;
        repeat (2) tick();
        chk("after_reset_idle", dm_respond_o, 0);
        chk("after_reset_request", dm_request_o, 0);

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
